// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters.
// Define SRAM_ARB_CLEAR_EN to compile in the zero-fill sweep that runs after reset.
module sram_port_arbiter #(
  parameter int NumReq     = 4,
  parameter int NumWords   = 1024,
  parameter int DataWidth  = 32,
  parameter int ByteWidth  = 8,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                busy_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam int RrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    StClear,
    StRun
  } state_e;

`ifdef SRAM_ARB_CLEAR_EN
  localparam state_e ResetState = StClear;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  logic [AddrWidth-1:0] clr_cnt_q;
  logic                 clearing;
`else
  localparam state_e ResetState = StRun;
`endif

  state_e               state_q;
  logic [RrWidth-1:0]   rr_q, rr_d;
  logic [NumReq-1:0]    rvalid_q;
  logic [NumReq-1:0]    gnt_vec;
  logic [RrWidth-1:0]   gnt_idx;
  logic                 gnt_any;
  logic                 grant_en;
  logic [RrWidth:0]     idx_w;

  // Search starts at rr_q and wraps; idx_w is one bit wider so the sum never overflows.
  always_comb begin
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_w   = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx_w = {1'b0, rr_q} + (RrWidth+1)'(i);
      if (idx_w >= (RrWidth+1)'(NumReq)) idx_w = idx_w - (RrWidth+1)'(NumReq);
      if (!gnt_any && req_i[idx_w[RrWidth-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[RrWidth-1:0];
        gnt_vec[idx_w[RrWidth-1:0]] = 1'b1;
      end
    end
  end

  assign rr_d     = (gnt_idx == RrWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
  assign grant_en = (state_q == StRun) && !rst_i;

  assign gnt_o    = grant_en ? gnt_vec : '0;
  assign rvalid_o = rst_i ? '0 : rvalid_q;
  assign rdata_o  = sram_rdata_i;

`ifdef SRAM_ARB_CLEAR_EN
  assign clearing = (state_q == StClear) && !rst_i;
  assign busy_o   = clearing;
`else
  assign busy_o   = 1'b0;
`endif

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (grant_en && gnt_any) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i[gnt_idx];
      sram_addr_o  = addr_i[gnt_idx];
      sram_wdata_o = wdata_i[gnt_idx];
      sram_be_o    = be_i[gnt_idx];
    end
`ifdef SRAM_ARB_CLEAR_EN
    if (clearing) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = clr_cnt_q;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ResetState;
      rr_q     <= '0;
      rvalid_q <= '0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      rvalid_q <= '0;
      case (state_q)
        StClear: begin
`ifdef SRAM_ARB_CLEAR_EN
          if (clr_cnt_q == LastAddr) state_q <= StRun;
          else clr_cnt_q <= clr_cnt_q + 1'b1;
`else
          state_q <= StRun;
`endif
        end
        StRun: begin
          // Writes are fire-and-forget; only reads get a data-valid pulse.
          if (gnt_any) begin
            rr_q <= rr_d;
            if (!we_i[gnt_idx]) rvalid_q <= gnt_vec;
          end
        end
        default: state_q <= ResetState;
      endcase
    end
  end

endmodule
